// File: rtl/controle_vedacao.sv
// Sealing-station controller: conveyor / capper sequencing with a cork-availability interlock.
// Optional sealed-bottle counter compiled in when VEDACAO_CONTADOR_GARRAFAS_EN is defined.
module controle_vedacao #(
    parameter logic [25:0] TEMPO_VEDACAO    = 26'd50000000,
    parameter logic [25:0] TEMPO_ESTABILIZA = 26'd12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sistema_ativo,
    input  logic       sensor_garrafa,
    input  logic [6:0] contador_valor,
    input  logic       alarme_rolha_vazia,
    output logic       esteira_ativa,
    output logic       atuador_vedacao,
    output logic       vedacao_concluida,
    output logic       aguardando_rolha,
    output logic [6:0] garrafas_vedadas
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        TRANSPORTE   = 3'd1,
        POSICIONANDO = 3'd2,
        SEM_ROLHA    = 3'd3,
        VEDANDO      = 3'd4,
        CONCLUIDO    = 3'd5,
        LIBERANDO    = 3'd6
    } estado_t;

    estado_t     estado_r;
    estado_t     estado_prox_s;
    logic [25:0] timer_r;
    logic        sensor_meta_r;
    logic        sensor_sync_r;
    logic        rolha_ok_s;

    assign rolha_ok_s = (contador_valor != 7'd0) && !alarme_rolha_vazia;

    // Two-flop synchronizer for the asynchronous bottle sensor.
    always_ff @(posedge clk) begin
        if (reset) begin
            sensor_meta_r <= 1'b0;
            sensor_sync_r <= 1'b0;
        end else begin
            sensor_meta_r <= sensor_garrafa;
            sensor_sync_r <= sensor_meta_r;
        end
    end

    // Next-state decision; bottle removal wins over the settle timeout.
    always_comb begin
        estado_prox_s = estado_r;
        case (estado_r)
            IDLE: begin
                if (sistema_ativo) estado_prox_s = TRANSPORTE;
                else               estado_prox_s = IDLE;
            end
            TRANSPORTE: begin
                if (!sistema_ativo)     estado_prox_s = IDLE;
                else if (sensor_sync_r) estado_prox_s = POSICIONANDO;
                else                    estado_prox_s = TRANSPORTE;
            end
            POSICIONANDO: begin
                if (!sensor_sync_r) begin
                    estado_prox_s = TRANSPORTE;
                end else if (timer_r == (TEMPO_ESTABILIZA - 26'd1)) begin
                    if (rolha_ok_s) estado_prox_s = VEDANDO;
                    else            estado_prox_s = SEM_ROLHA;
                end else begin
                    estado_prox_s = POSICIONANDO;
                end
            end
            SEM_ROLHA: begin
                if (!sistema_ativo)  estado_prox_s = IDLE;
                else if (rolha_ok_s) estado_prox_s = VEDANDO;
                else                 estado_prox_s = SEM_ROLHA;
            end
            VEDANDO: begin
                if (timer_r == (TEMPO_VEDACAO - 26'd1)) estado_prox_s = CONCLUIDO;
                else                                    estado_prox_s = VEDANDO;
            end
            CONCLUIDO: begin
                estado_prox_s = LIBERANDO;
            end
            LIBERANDO: begin
                if (sensor_sync_r)      estado_prox_s = LIBERANDO;
                else if (sistema_ativo) estado_prox_s = TRANSPORTE;
                else                    estado_prox_s = IDLE;
            end
            default: begin
                estado_prox_s = IDLE;
            end
        endcase
    end

    // State, timer and Moore outputs decoded from the next state so they move with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_r          <= IDLE;
            timer_r           <= 26'd0;
            esteira_ativa     <= 1'b0;
            atuador_vedacao   <= 1'b0;
            vedacao_concluida <= 1'b0;
            aguardando_rolha  <= 1'b0;
        end else begin
            estado_r <= estado_prox_s;
            if (estado_prox_s != estado_r) timer_r <= 26'd0;
            else                           timer_r <= timer_r + 26'd1;
            esteira_ativa     <= (estado_prox_s == TRANSPORTE) || (estado_prox_s == LIBERANDO);
            atuador_vedacao   <= (estado_prox_s == VEDANDO);
            vedacao_concluida <= (estado_prox_s == CONCLUIDO);
            aguardando_rolha  <= (estado_prox_s == SEM_ROLHA);
        end
    end

`ifdef VEDACAO_CONTADOR_GARRAFAS_EN
    logic [6:0] garrafas_r;

    // Sealed-bottle count, modulo 100, stepping on the same edge as the completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            garrafas_r <= 7'd0;
        end else if (estado_prox_s == CONCLUIDO) begin
            if (garrafas_r == 7'd99) garrafas_r <= 7'd0;
            else                     garrafas_r <= garrafas_r + 7'd1;
        end else begin
            garrafas_r <= garrafas_r;
        end
    end

    assign garrafas_vedadas = garrafas_r;
`else
    assign garrafas_vedadas = 7'd0;
`endif

endmodule

// File: tb/tb_controle_vedacao.sv
// Directed bench for controle_vedacao with short timing parameters and a per-cycle expectation queue.
module tb_controle_vedacao;

    logic       clk;
    logic       reset;
    logic       sistema_ativo;
    logic       sensor_garrafa;
    logic [6:0] contador_valor;
    logic       alarme_rolha_vazia;
    logic       esteira_ativa;
    logic       atuador_vedacao;
    logic       vedacao_concluida;
    logic       aguardando_rolha;
    logic [6:0] garrafas_vedadas;

`ifdef VEDACAO_CONTADOR_GARRAFAS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic       est;
        logic       atu;
        logic       con;
        logic       agu;
        logic [6:0] gv;
    } exp_t;

    exp_t       sb[$];
    int         total;
    int         passes;
    logic [6:0] gv_m;

    controle_vedacao #(
        .TEMPO_VEDACAO    (26'd10),
        .TEMPO_ESTABILIZA (26'd4)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .sistema_ativo      (sistema_ativo),
        .sensor_garrafa     (sensor_garrafa),
        .contador_valor     (contador_valor),
        .alarme_rolha_vazia (alarme_rolha_vazia),
        .esteira_ativa      (esteira_ativa),
        .atuador_vedacao    (atuador_vedacao),
        .vedacao_concluida  (vedacao_concluida),
        .aguardando_rolha   (aguardando_rolha),
        .garrafas_vedadas   (garrafas_vedadas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] expv);
        total = total + 1;
        assert (got === expv) passes = passes + 1;
        else $error("FAIL %s: got %0d expected %0d", tag, got, expv);
    endtask

    task automatic check_front();
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "/esteira"}, {6'd0, esteira_ativa}, {6'd0, e.est});
        chk({e.tag, "/atuador"}, {6'd0, atuador_vedacao}, {6'd0, e.atu});
        chk({e.tag, "/pulso"}, {6'd0, vedacao_concluida}, {6'd0, e.con});
        chk({e.tag, "/aguardando"}, {6'd0, aguardando_rolha}, {6'd0, e.agu});
        chk({e.tag, "/garrafas"}, garrafas_vedadas, e.gv);
        chk({e.tag, "/exclusao"}, {6'd0, esteira_ativa & atuador_vedacao}, 7'd0);
    endtask

    // Push the expected outputs for the next edge, advance one cycle, then compare.
    task automatic cyc(input string tag, input logic e_est, input logic e_atu,
                       input logic e_con, input logic e_agu);
        exp_t e;
        e.tag = tag;
        e.est = e_est;
        e.atu = e_atu;
        e.con = e_con;
        e.agu = e_agu;
        e.gv  = CNT_EN ? gv_m : 7'd0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_front();
    endtask

    task automatic bump_count();
        gv_m = (gv_m == 7'd99) ? 7'd0 : gv_m + 7'd1;
    endtask

    // Full seal starting from TRANSPORTE with corks available, ending back in TRANSPORTE.
    task automatic do_seal(input string tag);
        sensor_garrafa = 1'b1;
        cyc({tag, "/sync1"}, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc({tag, "/sync2"}, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc({tag, "/stop"}, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc({tag, "/settle"}, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) cyc({tag, "/seal"}, 1'b0, 1'b1, 1'b0, 1'b0);
        bump_count();
        cyc({tag, "/pulse"}, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc({tag, "/release"}, 1'b1, 1'b0, 1'b0, 1'b0);
        sensor_garrafa = 1'b0;
        repeat (3) cyc({tag, "/leave"}, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        total              = 0;
        passes             = 0;
        gv_m               = 7'd0;
        reset              = 1'b1;
        sistema_ativo      = 1'b0;
        sensor_garrafa     = 1'b0;
        contador_valor     = 7'd20;
        alarme_rolha_vazia = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        reset         = 1'b0;
        sistema_ativo = 1'b1;
        cyc("start", 1'b1, 1'b0, 1'b0, 1'b0);

        do_seal("nominal");

        // No corks: wait in SEM_ROLHA until both count and alarm allow sealing.
        contador_valor     = 7'd0;
        alarme_rolha_vazia = 1'b1;
        sensor_garrafa     = 1'b1;
        cyc("empty/sync1", 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("empty/sync2", 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("empty/stop", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc("empty/settle", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("empty/sem_rolha", 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("empty/hold", 1'b0, 1'b0, 1'b0, 1'b1);
        contador_valor = 7'd15;
        cyc("empty/alarm_blocks", 1'b0, 1'b0, 1'b0, 1'b1);
        alarme_rolha_vazia = 1'b0;
        repeat (10) cyc("empty/seal", 1'b0, 1'b1, 1'b0, 1'b0);
        bump_count();
        cyc("empty/pulse", 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("empty/release", 1'b1, 1'b0, 1'b0, 1'b0);
        sensor_garrafa = 1'b0;
        repeat (3) cyc("empty/leave", 1'b1, 1'b0, 1'b0, 1'b0);

        // Stop request during the seal: the bottle finishes, then the line idles.
        sensor_garrafa = 1'b1;
        cyc("stopseal/sync1", 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("stopseal/sync2", 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("stopseal/stop", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc("stopseal/settle", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) cyc("stopseal/seal_a", 1'b0, 1'b1, 1'b0, 1'b0);
        sistema_ativo = 1'b0;
        repeat (8) cyc("stopseal/seal_b", 1'b0, 1'b1, 1'b0, 1'b0);
        bump_count();
        cyc("stopseal/pulse", 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("stopseal/release", 1'b1, 1'b0, 1'b0, 1'b0);
        sensor_garrafa = 1'b0;
        repeat (2) cyc("stopseal/leave", 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("stopseal/idle", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("stopseal/idle_hold", 1'b0, 1'b0, 1'b0, 1'b0);

        // Bottle removed during settling: back to transport, no actuation.
        sistema_ativo = 1'b1;
        cyc("removed/restart", 1'b1, 1'b0, 1'b0, 1'b0);
        sensor_garrafa = 1'b1;
        cyc("removed/sync1", 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("removed/sync2", 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("removed/stop", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("removed/pos1", 1'b0, 1'b0, 1'b0, 1'b0);
        sensor_garrafa = 1'b0;
        repeat (2) cyc("removed/pos_wait", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("removed/transporte", 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) cyc("removed/hold", 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the fifth sealing cycle: everything clears, no pulse.
        sensor_garrafa = 1'b1;
        cyc("rstmid/sync1", 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("rstmid/sync2", 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("rstmid/stop", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc("rstmid/settle", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) cyc("rstmid/seal", 1'b0, 1'b1, 1'b0, 1'b0);
        reset          = 1'b1;
        sistema_ativo  = 1'b0;
        sensor_garrafa = 1'b0;
        gv_m           = 7'd0;
        cyc("rstmid/cleared", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("rstmid/held", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (2) cyc("rstmid/no_pulse", 1'b0, 1'b0, 1'b0, 1'b0);

        // One hundred seals: the counter reaches 99 and wraps to 0.
        sistema_ativo  = 1'b1;
        contador_valor = 7'd20;
        cyc("wrap/start", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            do_seal("wrap");
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
